qspi_mem_controller: RTL and testbench

Quad-SPI memory controller between the CPU core's memory request port and the shared QSPI pins (one flash, one PSRAM "RAM A"). It serialises each single-byte CPU read or write into a 1-4-4 SPI transaction: command on IO0, then address and data on IO3..IO0. It returns read data or write completion through a valid/ready request and single-pulse response handshake. Its spi_* outputs map directly onto the chip-level uio pins.

---
 rtl/qspi_mem_controller_if.sv | 26 ++
 rtl/qspi_mem_controller.sv | 94 +++++++++
 tb/tb_qspi_mem_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/qspi_mem_controller_if.sv
// qspi_mem_controller_if: CPU request/response port plus the shared QSPI pin bundle.
interface qspi_mem_controller_if #(parameter int ADDRESS_WIDTH = 16);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [7:0]               req_wdata;
  logic                     resp_valid;
  logic [7:0]               resp_rdata;
  logic [3:0]               spi_data_in;
  logic [3:0]               spi_data_out;
  logic [3:0]               spi_data_oe;
  logic                     spi_clk_out;
  logic                     spi_flash_select;
  logic                     spi_ram_a_select;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, spi_data_in,
    input  req_ready, resp_valid, resp_rdata, spi_data_out, spi_data_oe,
           spi_clk_out, spi_flash_select, spi_ram_a_select
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, spi_data_in,
    output req_ready, resp_valid, resp_rdata, spi_data_out, spi_data_oe,
           spi_clk_out, spi_flash_select, spi_ram_a_select
  );
endinterface

// File: rtl/qspi_mem_controller.sv
// qspi_mem_controller: serialises single-byte CPU reads/writes into 1-4-4 QSPI transactions.
module qspi_mem_controller #(
  parameter int         ADDRESS_WIDTH     = 16,
  parameter int         READ_DUMMY_CYCLES = 6,
  parameter logic [7:0] FLASH_READ_CMD    = 8'hEB,
  parameter logic [7:0] RAM_READ_CMD      = 8'hEB,
  parameter logic [7:0] RAM_WRITE_CMD     = 8'h38
) (
  input logic clock,
  input logic reset,
  qspi_mem_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;
  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [39:0] sh_q, sh_d;
  logic        wr_q, wr_d;
  logic        ram_q, ram_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        active;
  logic [3:0]  last;
  logic [7:0]  op;
  assign active = state_q inside {CMD, ADDR, DUMMY, DATA};
  assign last = state_q == CMD ? 4'd7 : state_q == ADDR ? 4'd5 :
                state_q == DUMMY ? 4'(READ_DUMMY_CYCLES - 1) : 4'd1;
  assign op = bus.req_addr[ADDRESS_WIDTH-1] ? (bus.req_write ? RAM_WRITE_CMD : RAM_READ_CMD)
                                            : FLASH_READ_CMD;
  // sh_q holds {opcode, wire address, write data}; its top bits are always the next to go out,
  // and read nibbles are shifted in at the bottom on the edge ending each SPI clock high phase.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    wr_d    = wr_q;
    ram_d   = ram_q;
    rdata_d = rdata_q;
    if (state_q == IDLE) begin
      if (bus.req_valid) begin
        wr_d    = bus.req_write;
        ram_d   = bus.req_addr[ADDRESS_WIDTH-1];
        sh_d    = {op, 24'(bus.req_addr[ADDRESS_WIDTH-2:0]), bus.req_wdata};
        phase_d = 1'b0;
        cnt_d   = 4'd0;
        state_d = (bus.req_write && !bus.req_addr[ADDRESS_WIDTH-1]) ? DONE : CMD;
        if (bus.req_write && !bus.req_addr[ADDRESS_WIDTH-1]) rdata_d = 8'h00;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else begin
      phase_d = ~phase_q;
      if (phase_q) begin
        sh_d = state_q == CMD ? {sh_q[38:0], 1'b0} :
               state_q == DUMMY ? sh_q : {sh_q[35:0], bus.spi_data_in};
        cnt_d = cnt_q == last ? 4'd0 : cnt_q + 4'd1;
        if (cnt_q == last)
          state_d = state_q == CMD ? ADDR :
                    state_q == ADDR ? ((wr_q || READ_DUMMY_CYCLES == 0) ? DATA : DUMMY) :
                    state_q == DUMMY ? DATA : DONE;
        if (state_q == DATA && cnt_q == last) rdata_d = wr_q ? 8'h00 : {sh_q[3:0], bus.spi_data_in};
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q   <= 4'd0;
      sh_q    <= 40'd0;
      wr_q    <= 1'b0;
      ram_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      ram_q   <= ram_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.req_ready        = state_q == IDLE && !reset;
  assign bus.resp_valid       = state_q == DONE;
  assign bus.resp_rdata       = rdata_q;
  assign bus.spi_clk_out      = active & phase_q;
  assign bus.spi_flash_select = !(active && !ram_q);
  assign bus.spi_ram_a_select = !(active && ram_q);
  assign bus.spi_data_oe      = state_q == CMD ? 4'b0001 :
                                (state_q == ADDR || (state_q == DATA && wr_q)) ? 4'b1111 : 4'b0000;
  assign bus.spi_data_out     = state_q == CMD ? {3'b000, sh_q[39]} :
                                bus.spi_data_oe == 4'b1111 ? sh_q[39:36] : 4'b0000;
endmodule

// File: tb/tb_qspi_mem_controller.sv
// tb_qspi_mem_controller: randomized scoreboard bench with QSPI flash/PSRAM device models.
module tb_qspi_mem_controller;
  localparam int D = 6;
  logic clock = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clock = ~clock;
  qspi_mem_controller_if #(.ADDRESS_WIDTH(16)) bus();
  qspi_mem_controller #(.ADDRESS_WIDTH(16), .READ_DUMMY_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  typedef struct {
    logic [7:0]  rdata;
    int          acc;
    int          lat;
    bit          spi;
    logic [7:0]  cmd;
    logic [23:0] addr;
    bit          ram;
    int          nclk;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] ref_flash [32768];
  logic [7:0] ref_ram   [32768];
  logic [7:0] dev_flash [32768];
  logic [7:0] dev_ram   [32768];
  int tests = 0, fails = 0, cyc = 0, last_acc = 0, prev_acc = 0;
  bit in_txn = 0, txn_seen = 0, t_ram = 0;
  int n = 0, lo = 0, first = 0, oe_err = 0, idle_err = 0;
  logic [7:0] t_cmd, b;
  logic [23:0] t_addr;
  logic [3:0] wd_hi;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // device models, response monitor and acceptance scoreboard, all sampled mid-cycle
  initial forever begin
    @(negedge clock);
    cyc++;
    bus.spi_data_in = 4'($urandom);
    if (bus.spi_flash_select === 1'b0 && bus.spi_ram_a_select === 1'b0) idle_err++;
    if (bus.spi_flash_select === 1'b0 || bus.spi_ram_a_select === 1'b0) begin
      if (!in_txn) begin
        in_txn = 1; txn_seen = 1; n = 0; lo = 0; first = cyc;
        t_ram = (bus.spi_ram_a_select === 1'b0); t_cmd = 0; t_addr = 0;
      end
      lo++;
      if (bus.spi_clk_out === 1'b1) begin
        if (n < 8) begin
          t_cmd = {t_cmd[6:0], bus.spi_data_out[0]};
          if (bus.spi_data_oe !== 4'b0001) oe_err++;
        end else if (n < 14) begin
          t_addr = {t_addr[19:0], bus.spi_data_out};
          if (bus.spi_data_oe !== 4'b1111) oe_err++;
        end else if (t_ram && t_cmd == 8'h38) begin
          if (bus.spi_data_oe !== 4'b1111) oe_err++;
          if (n == 14) wd_hi = bus.spi_data_out;
          else if (n == 15) dev_ram[t_addr[14:0]] = {wd_hi, bus.spi_data_out};
        end else begin
          if (bus.spi_data_oe !== 4'b0000 || (n < 14 + D && bus.spi_data_out !== 4'b0000)) oe_err++;
          b = t_ram ? dev_ram[t_addr[14:0]] : dev_flash[t_addr[14:0]];
          if (n == 14 + D) bus.spi_data_in = b[7:4];
          else if (n == 15 + D) bus.spi_data_in = b[3:0];
        end
        n++;
      end
    end else begin
      in_txn = 0;
      if (bus.spi_clk_out !== 1'b0) idle_err++;
    end
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_resp: resp_valid with no outstanding request (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("latency", cyc - e.acc, e.lat);
        if (e.spi) begin
          chk("opcode", t_cmd, e.cmd);
          chk("wire_addr", t_addr, e.addr);
          chk("device", t_ram, e.ram);
          chk("spi_clocks", n, e.nclk);
          chk("select_cycles", lo, 2 * e.nclk);
          chk("select_start", first - e.acc, 1);
          chk("oe_errors", oe_err, 0);
        end else chk("no_spi_activity", txn_seen, 0);
        chk("idle_errors", idle_err, 0);
        txn_seen = 0; oe_err = 0;
      end
    end
    if (bus.req_valid && bus.req_ready === 1'b1) begin
      prev_acc = last_acc; last_acc = cyc;
      e.acc = cyc;
      e.ram = bus.req_addr[15];
      e.addr = {9'd0, bus.req_addr[14:0]};
      e.spi = !(bus.req_write && !bus.req_addr[15]);
      e.cmd = (e.ram && bus.req_write) ? 8'h38 : 8'hEB;
      e.nclk = bus.req_write ? 16 : 8 + 6 + D + 2;
      e.lat = e.spi ? 2 * e.nclk + 1 : 1;
      e.rdata = bus.req_write ? 8'h00 : e.ram ? ref_ram[bus.req_addr[14:0]] : ref_flash[bus.req_addr[14:0]];
      if (bus.req_write && e.ram) ref_ram[bus.req_addr[14:0]] = bus.req_wdata;
      sb.push_back(e);
    end
  end
  task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] d);
    int t = 0;
    bus.req_valid = 1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    do begin @(negedge clock); t++; end while (bus.req_ready !== 1'b1 && t < 200);
    if (bus.req_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, expected 1", bus.req_ready, t);
    end
    @(posedge clock); #1;
    bus.req_valid = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || bus.req_ready !== 1'b1) && t < 500) begin @(negedge clock); t++; end
    if (t >= 500) begin
      tests++; fails++;
      $display("FAIL idle_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    @(posedge clock); #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 32768; i++) begin
      ref_flash[i] = 8'($urandom); dev_flash[i] = ref_flash[i];
      ref_ram[i] = 8'($urandom);   dev_ram[i] = ref_ram[i];
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_spi_clk", bus.spi_clk_out, 0);
    chk("rst_oe", bus.spi_data_oe, 0);
    chk("rst_out", bus.spi_data_out, 0);
    chk("rst_flash_sel", bus.spi_flash_select, 1);
    chk("rst_ram_sel", bus.spi_ram_a_select, 1);
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk("idle_req_ready", bus.req_ready, 1);
    chk("idle_rdata", bus.resp_rdata, 0);
    @(posedge clock); #1;
    ref_flash[16'h0123] = 8'hA5; dev_flash[16'h0123] = 8'hA5;
    issue(0, 16'h0123, 8'h00); wait_idle();
    issue(1, 16'h8010, 8'h3C); wait_idle();
    chk("ram_store_8010", dev_ram[15'h0010], 8'h3C);
    issue(1, 16'hFFFF, 8'h96); wait_idle();
    issue(0, 16'hFFFF, 8'h00); wait_idle();
    issue(1, 16'h0040, 8'h55); wait_idle();
    chk("rdata_after_fwrite", bus.resp_rdata, 0);
    issue(0, 16'h8123, 8'h00);
    repeat (19) @(posedge clock);
    #1 reset = 1;
    @(negedge clock);
    chk("midrst_req_ready", bus.req_ready, 0);
    @(posedge clock); #1;
    chk("midrst_flash_sel", bus.spi_flash_select, 1);
    chk("midrst_ram_sel", bus.spi_ram_a_select, 1);
    chk("midrst_spi_clk", bus.spi_clk_out, 0);
    chk("midrst_oe", bus.spi_data_oe, 0);
    sb.delete(); txn_seen = 0; oe_err = 0;
    reset = 0;
    repeat (50) @(posedge clock); #1;
    chk("postrst_req_ready", bus.req_ready, 1);
    issue(0, 16'h8123, 8'h00); wait_idle();
    issue(0, 16'h0200, 8'h00);
    issue(1, 16'h8200, 8'h77);
    chk("b2b_accept_gap", last_acc - prev_acc, 46);
    wait_idle();
    issue(0, 16'h8200, 8'h00); wait_idle();
    repeat (40) begin
      issue(1'($urandom), 16'($urandom), 8'($urandom));
      wait_idle();
    end
    chk("final_idle_errors", idle_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
